// File: rtl/rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rom_stream_reader                                               |
// | Purpose  : Walks consecutive byte pairs of a dual-read ROM and emits them  |
// |            as a registered 16-bit valid/ready stream with running checksum |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rom_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_W-1:0]     BaseAddress,
    input  logic [ADDR_W-1:0]     WordCount,
    output logic [ADDR_W-1:0]     ReadAddress1,
    output logic [ADDR_W-1:0]     ReadAddress2,
    input  logic [DATA_W-1:0]     Value1,
    input  logic [DATA_W-1:0]     Value2,
    output logic [2*DATA_W-1:0]   OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_W-1:0]     Checksum
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_remaining;
    logic [2*DATA_W-1:0]   r_outData;
    logic                  r_outValid;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_W-1:0]     r_checksum;
    logic                  w_capture;

    // A new pair is latched whenever the output register is empty or being drained.
    assign w_capture = (r_state == c_READ) && (!r_outValid || OutReady);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= c_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        r_addr      <= BaseAddress;
                        r_remaining <= WordCount;
                        r_checksum  <= '0;
                        if (WordCount != '0) begin
                            r_state <= c_READ;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_READ: begin
                    if (w_capture) begin
                        r_outData   <= {Value2, Value1};
                        r_outValid  <= 1'b1;
                        r_checksum  <= r_checksum + Value1 + Value2;
                        r_addr      <= r_addr + ADDR_W'(2);
                        r_remaining <= r_remaining - ADDR_W'(1);
                        if (r_remaining == ADDR_W'(1)) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (r_outValid && OutReady) begin
                        r_outValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ReadAddress1 = r_addr;
    assign ReadAddress2 = r_addr + ADDR_W'(1);
    assign OutData      = r_outData;
    assign OutValid     = r_outValid;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign Checksum     = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rom_stream_reader                                            |
// | Purpose  : Self-checking bench: ROM model, run-level reference, stimulus   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        Reset, Start, OutReady;
    logic [7:0]  BaseAddress, WordCount, ReadAddress1, ReadAddress2;
    logic [7:0]  Value1, Value2, Checksum;
    logic [15:0] OutData;
    logic        OutValid, Busy, Done;
    logic [7:0]  rom [256];

    always #5 clk = ~clk;

    assign Value1 = rom[ReadAddress1];
    assign Value2 = rom[ReadAddress2];

    rom_stream_reader #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clock(clk), .Reset(Reset), .Start(Start),
        .BaseAddress(BaseAddress), .WordCount(WordCount),
        .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2),
        .Value1(Value1), .Value2(Value2),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .Busy(Busy), .Done(Done), .Checksum(Checksum)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Run-level reference: phase 0 idle, 1 running, 2 done-cycle.
    int          phase = 0;
    int          hs, cnt, activeCycles, cap;
    logic [7:0]  mBase, expSum, lastSum, a;
    logic [15:0] lastData;
    logic        expValid;
    logic [15:0] expWords[$];
    logic [15:0] seen[$];

    always @(negedge clk) begin
        if (Reset) begin
            phase    = 0;
            lastSum  = 8'h00;
            lastData = 16'h0000;
            expWords.delete();
            check("rst_valid", 32'(OutValid), 32'd0);
            check("rst_busy", 32'(Busy), 32'd0);
            check("rst_done", 32'(Done), 32'd0);
            check("rst_sum", 32'(Checksum), 32'd0);
            check("rst_data", 32'(OutData), 32'd0);
            check("rst_ra1", 32'(ReadAddress1), 32'd0);
            check("rst_ra2", 32'(ReadAddress2), 32'd1);
        end else begin
            expValid = (phase == 1) && (activeCycles > 0);
            check("busy", 32'(Busy), 32'(phase == 1));
            check("done", 32'(Done), 32'(phase == 2));
            check("valid", 32'(OutValid), 32'(expValid));
            if (expValid) check("data", 32'(OutData), 32'(expWords[0]));
            else          check("data_hold", 32'(OutData), 32'(lastData));
            if (phase != 1) check("checksum", 32'(Checksum), 32'(lastSum));
            if (phase == 1) begin
                cap = hs + (expValid ? 1 : 0);
                if (cap < cnt) begin
                    a = mBase + 8'(2 * cap);
                    check("ra1", 32'(ReadAddress1), 32'(a));
                    check("ra2", 32'(ReadAddress2), 32'(8'(a + 8'd1)));
                end
            end
            case (phase)
                0: if (Start) begin
                    mBase  = BaseAddress;
                    cnt    = int'(WordCount);
                    hs     = 0;
                    activeCycles = 0;
                    expSum = 8'h00;
                    expWords.delete();
                    for (int i = 0; i < cnt; i++) begin
                        a = mBase + 8'(2 * i);
                        expWords.push_back({rom[8'(a + 8'd1)], rom[a]});
                        expSum = expSum + rom[a] + rom[8'(a + 8'd1)];
                    end
                    if (cnt == 0) begin
                        phase   = 2;
                        lastSum = 8'h00;
                    end else begin
                        phase = 1;
                    end
                end
                1: begin
                    activeCycles++;
                    if (expValid && OutReady) begin
                        seen.push_back(OutData);
                        lastData = expWords.pop_front();
                        hs++;
                        if (hs == cnt) begin
                            phase   = 2;
                            lastSum = expSum;
                        end
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (phase != 0 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        check("run_timeout", 32'(phase), 32'd0);
    endtask

    logic [7:0] firstRa1, firstRa2;

    task automatic runCase(input logic [7:0] base, input logic [7:0] count,
                           input int stall, input bit poke);
        seen.delete();
        @(posedge clk); #2;
        BaseAddress = base; WordCount = count; Start = 1'b1;
        OutReady = (stall == 0);
        @(posedge clk); #2;
        Start = 1'b0;
        firstRa1 = ReadAddress1; firstRa2 = ReadAddress2;
        if (poke) begin
            @(posedge clk); #2;
            Start = 1'b1; BaseAddress = 8'h80; WordCount = 8'd5;
            @(posedge clk); #2;
            Start = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall + 1) @(posedge clk);
            #2 OutReady = 1'b1;
        end
        waitIdle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h1F; rom[1] = 8'h2B; rom[2] = 8'hD3; rom[3] = 8'hED; rom[255] = 8'h16;
        Reset = 1'b1; Start = 1'b0; OutReady = 1'b0; BaseAddress = 8'h00; WordCount = 8'h00;
        #12;
        check("init_valid", 32'(OutValid), 32'd0);
        check("init_ra2", 32'(ReadAddress2), 32'd1);
        @(posedge clk); #2 Reset = 1'b0;

        // Two words back to back
        runCase(8'h00, 8'd2, 0, 1'b0);
        check("c1_n", 32'(seen.size()), 32'd2);
        check("c1_w0", 32'(seen[0]), 32'h2B1F);
        check("c1_w1", 32'(seen[1]), 32'hEDD3);
        check("c1_sum", 32'(Checksum), 32'h0A);

        // Pair straddling the top of the address space
        runCase(8'hFF, 8'd1, 0, 1'b0);
        check("c2_ra1", 32'(firstRa1), 32'hFF);
        check("c2_ra2", 32'(firstRa2), 32'h00);
        check("c2_w0", 32'(seen[0]), 32'h1F16);
        check("c2_sum", 32'(Checksum), 32'h35);

        runCase(8'h10, 8'd0, 0, 1'b0);
        check("c3_n", 32'(seen.size()), 32'd0);
        check("c3_sum", 32'(Checksum), 32'h00);

        runCase(8'h00, 8'd2, 3, 1'b0);
        check("c4_w0", 32'(seen[0]), 32'h2B1F);
        check("c4_w1", 32'(seen[1]), 32'hEDD3);
        check("c4_sum", 32'(Checksum), 32'h0A);

        runCase(8'h00, 8'd2, 0, 1'b1);
        check("c5_n", 32'(seen.size()), 32'd2);
        check("c5_w1", 32'(seen[1]), 32'hEDD3);
        check("c5_sum", 32'(Checksum), 32'h0A);

        // Asynchronous reset in the middle of a run
        @(posedge clk); #2;
        BaseAddress = 8'h00; WordCount = 8'd10; Start = 1'b1; OutReady = 1'b1;
        @(posedge clk); #2 Start = 1'b0;
        repeat (3) @(posedge clk);
        #3 Reset = 1'b1;
        #1;
        check("c6_valid", 32'(OutValid), 32'd0);
        check("c6_busy", 32'(Busy), 32'd0);
        check("c6_sum", 32'(Checksum), 32'd0);
        @(posedge clk); #2 Reset = 1'b0;
        runCase(8'h00, 8'd2, 0, 1'b0);
        check("c6_w0", 32'(seen[0]), 32'h2B1F);
        check("c6_sum2", 32'(Checksum), 32'h0A);

        // Randomised runs with back-pressure and stray Start pulses
        for (int r = 0; r < 30; r++) begin
            int n;
            @(posedge clk); #2;
            BaseAddress = 8'($urandom);
            WordCount = (r % 8 == 3) ? 8'(130 + $urandom_range(0, 9)) : 8'($urandom_range(0, 11));
            Start = 1'b1;
            OutReady = ($urandom_range(0, 3) != 0);
            n = 0;
            do begin
                @(posedge clk); #2;
                OutReady = ($urandom_range(0, 3) != 0);
                Start = ($urandom_range(0, 7) == 0);
                BaseAddress = 8'($urandom);
                WordCount = 8'($urandom_range(0, 11));
                n++;
            end while (phase != 0 && n < 2000);
            Start = 1'b0;
            waitIdle();
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
